// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: 2-bit saturating BHT plus a direct-mapped tagged BTB,
// trained by resolution packets from the execute-stage branch resolver.
module branch_predictor #(
   parameter int ADDR_WIDTH  = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int BTB_ENTRIES = 32,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fetch_valid,
   input  logic [ADDR_WIDTH-1:0] fetch_pc,
   output logic                  predict_taken,
   output logic [ADDR_WIDTH-1:0] predict_target,
   input  logic                  update_valid,
   input  logic [ADDR_WIDTH-1:0] update_pc,
   input  logic                  update_taken,
   input  logic [ADDR_WIDTH-1:0] update_target,
   input  logic                  update_mispredict,
   output logic [CNT_WIDTH-1:0]  branch_count,
   output logic [CNT_WIDTH-1:0]  mispredict_count
);

   localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);
   localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W     = ADDR_WIDTH - BTB_IDX_W - 2;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   // Table state
   logic [1:0]            bht_reg        [BHT_ENTRIES];
   logic                  btb_valid_reg  [BTB_ENTRIES];
   logic [TAG_W-1:0]      btb_tag_reg    [BTB_ENTRIES];
   logic [ADDR_WIDTH-1:0] btb_target_reg [BTB_ENTRIES];

   logic [CNT_WIDTH-1:0]  branch_count_reg;
   logic [CNT_WIDTH-1:0]  mispredict_count_reg;

   // Fetch-side index/tag extraction
   logic [BHT_IDX_W-1:0]  fetch_bht_idx;
   logic [BTB_IDX_W-1:0]  fetch_btb_idx;
   logic [TAG_W-1:0]      fetch_tag;
   logic                  fetch_hit;
   logic [ADDR_WIDTH-1:0] fetch_seq_pc;

   // Update-side index/tag extraction
   logic [BHT_IDX_W-1:0]  upd_bht_idx;
   logic [BTB_IDX_W-1:0]  upd_btb_idx;
   logic [TAG_W-1:0]      upd_tag;
   logic [1:0]            bht_next;
   logic                  bht_we;
   logic                  btb_we;

   // Byte-offset bits of the resolved PC play no part in indexing or tagging.
   logic                  unused_upd_pc_bits;

   assign fetch_bht_idx = fetch_pc[BHT_IDX_W+1:2];
   assign fetch_btb_idx = fetch_pc[BTB_IDX_W+1:2];
   assign fetch_tag     = fetch_pc[ADDR_WIDTH-1:BTB_IDX_W+2];
   assign fetch_seq_pc  = fetch_pc + ADDR_WIDTH'(4);

   assign upd_bht_idx   = update_pc[BHT_IDX_W+1:2];
   assign upd_btb_idx   = update_pc[BTB_IDX_W+1:2];
   assign upd_tag       = update_pc[ADDR_WIDTH-1:BTB_IDX_W+2];

   assign unused_upd_pc_bits = ^update_pc[1:0];

   // Prediction reads table state directly; a same-cycle update is not bypassed.
   // Gating with rst_n keeps the output quiet while stale tables await the reset edge.
   always_comb begin
      fetch_hit      = fetch_valid & rst_n
                     & btb_valid_reg[fetch_btb_idx]
                     & (btb_tag_reg[fetch_btb_idx] == fetch_tag);
      predict_taken  = fetch_hit & bht_reg[fetch_bht_idx][1];
      predict_target = predict_taken ? btb_target_reg[fetch_btb_idx] : fetch_seq_pc;
   end

   // Saturating 2-bit counter step for the entry being trained
   always_comb begin
      bht_next = bht_reg[upd_bht_idx];
      if (update_taken) begin
         if (bht_reg[upd_bht_idx] != 2'b11) begin
            bht_next = bht_reg[upd_bht_idx] + 2'b01;
         end
      end else begin
         if (bht_reg[upd_bht_idx] != 2'b00) begin
            bht_next = bht_reg[upd_bht_idx] - 2'b01;
         end
      end
   end

   assign bht_we = update_valid;
   assign btb_we = rst_n & update_valid & update_taken;

   generate
      for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               bht_reg[gi] <= 2'b01;
            end else if (bht_we && (upd_bht_idx == BHT_IDX_W'(gi))) begin
               bht_reg[gi] <= bht_next;
            end
         end
      end

      for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_btb
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               btb_valid_reg[gi] <= 1'b0;
            end else if (btb_we && (upd_btb_idx == BTB_IDX_W'(gi))) begin
               btb_valid_reg[gi] <= 1'b1;
            end
         end

         // Tag/target need no reset: they are only observed behind the valid bit.
         always_ff @(posedge clk) begin
            if (btb_we && (upd_btb_idx == BTB_IDX_W'(gi))) begin
               btb_tag_reg[gi]    <= upd_tag;
               btb_target_reg[gi] <= update_target;
            end
         end
      end
   endgenerate

   // Performance counters saturate at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         branch_count_reg     <= '0;
         mispredict_count_reg <= '0;
      end else if (update_valid) begin
         if (branch_count_reg != CNT_MAX) begin
            branch_count_reg <= branch_count_reg + CNT_WIDTH'(1);
         end
         if (update_mispredict && (mispredict_count_reg != CNT_MAX)) begin
            mispredict_count_reg <= mispredict_count_reg + CNT_WIDTH'(1);
         end
      end
   end

   assign branch_count     = branch_count_reg;
   assign mispredict_count = mispredict_count_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed and randomized checks of branch_predictor against a table-level reference model.
module tb_branch_predictor;

   localparam int CW   = 6;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          fetch_valid;
   logic [31:0]   fetch_pc;
   logic          predict_taken;
   logic [31:0]   predict_target;
   logic          update_valid;
   logic [31:0]   update_pc;
   logic          update_taken;
   logic [31:0]   update_target;
   logic          update_mispredict;
   logic [CW-1:0] branch_count;
   logic [CW-1:0] mispredict_count;

   int checks = 0;
   int errors = 0;

   // Reference model: counters as plain ints 0..3, BTB keeps the full trained PC.
   int          m_cnt   [64];
   bit          m_valid [32];
   logic [31:0] m_pc    [32];
   logic [31:0] m_tgt   [32];
   int          m_bc;
   int          m_mc;

   branch_predictor #(
      .ADDR_WIDTH (32),
      .BHT_ENTRIES(64),
      .BTB_ENTRIES(32),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .fetch_valid      (fetch_valid),
      .fetch_pc         (fetch_pc),
      .predict_taken    (predict_taken),
      .predict_target   (predict_target),
      .update_valid     (update_valid),
      .update_pc        (update_pc),
      .update_taken     (update_taken),
      .update_target    (update_target),
      .update_mispredict(update_mispredict),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 64; i++) m_cnt[i] = 1;
      for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
      m_bc = 0;
      m_mc = 0;
   endtask

   task automatic model_update();
      int bi;
      int ti;
      bi = int'((update_pc / 4) % 64);
      ti = int'((update_pc / 4) % 32);
      m_cnt[bi] = update_taken ? ((m_cnt[bi] < 3) ? m_cnt[bi] + 1 : 3)
                               : ((m_cnt[bi] > 0) ? m_cnt[bi] - 1 : 0);
      if (update_taken) begin
         m_valid[ti] = 1'b1;
         m_pc[ti]    = update_pc;
         m_tgt[ti]   = update_target;
      end
      if (m_bc < CMAX) m_bc++;
      if (update_mispredict && m_mc < CMAX) m_mc++;
   endtask

   task automatic drive(input bit fv, input logic [31:0] fpc, input bit uv, input logic [31:0] upc,
                        input bit ut, input logic [31:0] utgt, input bit um);
      fetch_valid       = fv;
      fetch_pc          = fpc;
      update_valid      = uv;
      update_pc         = upc;
      update_taken      = ut;
      update_target     = utgt;
      update_mispredict = um;
   endtask

   // Mid-cycle: compare outputs against the model's view of the current state.
   task automatic step();
      int  bi;
      int  ti;
      bit  hit;
      bit  exp_tk;
      logic [31:0] exp_tg;
      #4;
      bi  = int'((fetch_pc / 4) % 64);
      ti  = int'((fetch_pc / 4) % 32);
      hit = rst_n && fetch_valid && m_valid[ti] && ((m_pc[ti] / 128) == (fetch_pc / 128));
      exp_tk = hit && (m_cnt[bi] >= 2);
      exp_tg = exp_tk ? m_tgt[ti] : fetch_pc + 32'd4;
      check("model_taken", 32'(predict_taken), 32'(exp_tk));
      check("model_target", predict_target, exp_tg);
      check("model_branch_count", 32'(branch_count), 32'(m_bc));
      check("model_mispredict_count", 32'(mispredict_count), 32'(m_mc));
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_reset();
      else if (update_valid) model_update();
      #1;
   endtask

   function automatic logic [31:0] rand_pc();
      return (32'($urandom_range(0, 63)) << 2) | (32'($urandom_range(0, 3)) << 8);
   endfunction

   initial begin
      model_reset();
      rst_n = 1'b0;
      drive(1, 32'h100, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      tick();
      rst_n = 1'b1;

      // Reset state
      drive(1, 32'h100, 0, 0, 0, 0, 0);
      step();
      check("rst_taken", 32'(predict_taken), 32'd0);
      check("rst_target", predict_target, 32'h104);
      check("rst_bc", 32'(branch_count), 32'd0);
      check("rst_mc", 32'(mispredict_count), 32'd0);
      tick();

      // First taken training
      drive(0, 32'h100, 1, 32'h100, 1, 32'h200, 1);
      step(); tick();
      drive(1, 32'h100, 0, 0, 0, 0, 0);
      step();
      check("train_taken", 32'(predict_taken), 32'd1);
      check("train_target", predict_target, 32'h200);
      check("train_bc", 32'(branch_count), 32'd1);
      check("train_mc", 32'(mispredict_count), 32'd1);
      tick();

      // Two not-taken updates drive the counter to strongly not-taken
      drive(0, 32'h0, 1, 32'h100, 0, 32'h0, 0);
      step(); tick();
      step(); tick();
      drive(1, 32'h100, 0, 0, 0, 0, 0);
      step();
      check("nt_taken", 32'(predict_taken), 32'd0);
      check("nt_target", predict_target, 32'h104);
      tick();

      // BTB alias between 0x100 and 0x180
      drive(0, 32'h0, 1, 32'h100, 1, 32'h200, 0);
      step(); tick();
      step(); tick();
      drive(1, 32'h180, 0, 0, 0, 0, 0);
      step();
      check("alias_taken", 32'(predict_taken), 32'd0);
      check("alias_target", predict_target, 32'h184);
      tick();
      drive(0, 32'h0, 1, 32'h180, 1, 32'h300, 0);
      step(); tick();
      drive(1, 32'h100, 0, 0, 0, 0, 0);
      step();
      check("evict_taken", 32'(predict_taken), 32'd0);
      check("evict_target", predict_target, 32'h104);
      tick();

      // Same-cycle fetch and update: no bypass
      drive(0, 32'h0, 1, 32'h100, 1, 32'h200, 0);
      step(); tick();
      drive(0, 32'h0, 1, 32'h100, 0, 32'h0, 0);
      step(); tick();
      step(); tick();
      drive(1, 32'h100, 1, 32'h100, 1, 32'h200, 0);
      step();
      check("same_cycle_taken", 32'(predict_taken), 32'd0);
      tick();
      drive(1, 32'h100, 0, 0, 0, 0, 0);
      step();
      check("next_cycle_taken", 32'(predict_taken), 32'd1);
      check("next_cycle_target", predict_target, 32'h200);
      tick();

      // Randomized traffic with heavy aliasing
      for (int i = 0; i < 300; i++) begin
         drive($urandom_range(0, 4) != 0, rand_pc(), $urandom_range(0, 1) == 1, rand_pc(),
               $urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 2) == 0);
         step(); tick();
      end

      // Counter saturation
      for (int i = 0; i < 70; i++) begin
         drive(0, 32'h0, 1, rand_pc(), 0, 32'h0, 1);
         step(); tick();
      end
      drive(0, 32'h0, 0, 0, 0, 0, 0);
      step();
      check("sat_mc", 32'(mispredict_count), 32'(CMAX));
      check("sat_bc", 32'(branch_count), 32'(CMAX));
      tick();
      drive(0, 32'h0, 1, 32'h100, 1, 32'h200, 1);
      step(); tick();
      drive(0, 32'h0, 0, 0, 0, 0, 0);
      step();
      check("sat_hold_mc", 32'(mispredict_count), 32'(CMAX));
      tick();

      // Top-of-memory entry trained taken, then a reset discards a same-cycle update
      drive(0, 32'h0, 1, 32'hFFFF_FFFC, 1, 32'h40, 0);
      for (int i = 0; i < 3; i++) begin
         step(); tick();
      end
      drive(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
      step();
      check("top_taken", 32'(predict_taken), 32'd1);
      check("top_target", predict_target, 32'h40);
      tick();
      rst_n = 1'b0;
      drive(1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 1, 32'h40, 1);
      step();
      check("in_reset_taken", 32'(predict_taken), 32'd0);
      tick();
      rst_n = 1'b1;
      drive(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
      step();
      check("wrap_taken", 32'(predict_taken), 32'd0);
      check("wrap_target", predict_target, 32'h0000_0000);
      check("post_rst_bc", 32'(branch_count), 32'd0);
      check("post_rst_mc", 32'(mispredict_count), 32'd0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
